// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS pipeline: word/address types,
// fetch FSM states and the reset/bubble encodings.
package mips_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;

    localparam addr_t DEFAULT_RESET_PC = 32'h0000_0000;
    localparam word_t DEFAULT_NOP_INST = 32'h0000_0000;

    // Instruction fetch always targets word boundaries.
    localparam addr_t WORD_ALIGN_MASK  = 32'hFFFF_FFFC;
    localparam addr_t PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC helper: sequential PC+4 plus the prioritised
// redirect target (jr > j > branch), forced onto a word boundary.
module fetch_next_pc
    import mips_pkg::*;
(
    input  addr_t i_pc,
    input  logic  i_branch,
    input  addr_t i_branch_target,
    input  logic  i_jump,
    input  addr_t i_jump_target,
    input  logic  i_jump_reg,
    input  addr_t i_jump_reg_target,
    output addr_t o_pc_plus4,
    output logic  o_redirect,
    output addr_t o_redirect_pc
);

    addr_t w_target;

    always_comb begin
        w_target = i_branch_target;
        if (i_jump)
            w_target = i_jump_target;
        if (i_jump_reg)
            w_target = i_jump_reg_target;
    end

    assign o_pc_plus4    = i_pc + PC_STEP;
    assign o_redirect    = i_branch | i_jump | i_jump_reg;
    assign o_redirect_pc = w_target & WORD_ALIGN_MASK;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address and fills
// the IF/ID register, honouring halt, redirect and stall from decode.
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter addr_t RESET_PC = DEFAULT_RESET_PC,
    parameter word_t NOP_INST = DEFAULT_NOP_INST
)(
    input  logic        Clk,
    input  logic        Rst_n,
    output logic [31:0] Addr,
    input  logic [31:0] Inst,
    input  logic        Stall,
    input  logic        Branch,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        JumpReg,
    input  logic [31:0] JumpRegTarget,
    input  logic        Halt,
    output logic [31:0] IF_ID_Inst,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        Halted,
    output logic [31:0] FetchCount
);

    fetch_state_t r_state, w_state_next;
    addr_t        r_pc, w_pc_next;
    word_t        r_if_inst, w_if_inst_next;
    addr_t        r_if_pc4, w_if_pc4_next;
    logic         r_if_valid, w_if_valid_next;
    word_t        r_fetch_count, w_fetch_count_next;

    addr_t        w_pc_plus4;
    logic         w_redirect;
    addr_t        w_redirect_pc;

    fetch_next_pc u_next_pc (
        .i_pc              (r_pc),
        .i_branch          (Branch),
        .i_branch_target   (BranchTarget),
        .i_jump            (Jump),
        .i_jump_target     (JumpTarget),
        .i_jump_reg        (JumpReg),
        .i_jump_reg_target (JumpRegTarget),
        .o_pc_plus4        (w_pc_plus4),
        .o_redirect        (w_redirect),
        .o_redirect_pc     (w_redirect_pc)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_if_inst     <= NOP_INST;
            r_if_pc4      <= '0;
            r_if_valid    <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_if_inst     <= w_if_inst_next;
            r_if_pc4      <= w_if_pc4_next;
            r_if_valid    <= w_if_valid_next;
            r_fetch_count <= w_fetch_count_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_if_inst_next     = r_if_inst;
        w_if_pc4_next      = r_if_pc4;
        w_if_valid_next    = r_if_valid;
        w_fetch_count_next = r_fetch_count;

        case (r_state)
            BOOT: begin
                // Settling cycle for the memory: PC stays put, IF/ID gets a bubble.
                w_state_next    = RUN;
                w_if_inst_next  = NOP_INST;
                w_if_pc4_next   = '0;
                w_if_valid_next = 1'b0;
            end
            RUN: begin
                if (Halt) begin
                    w_state_next    = HALTED;
                    w_if_inst_next  = NOP_INST;
                    w_if_pc4_next   = '0;
                    w_if_valid_next = 1'b0;
                end else if (w_redirect) begin
                    // The instruction fetched this cycle is on the wrong path.
                    w_pc_next       = w_redirect_pc;
                    w_if_inst_next  = NOP_INST;
                    w_if_pc4_next   = '0;
                    w_if_valid_next = 1'b0;
                end else if (!Stall) begin
                    w_pc_next          = w_pc_plus4;
                    w_if_inst_next     = Inst;
                    w_if_pc4_next      = w_pc_plus4;
                    w_if_valid_next    = 1'b1;
                    w_fetch_count_next = r_fetch_count + 32'd1;
                end
            end
            HALTED: begin
                w_if_inst_next  = NOP_INST;
                w_if_pc4_next   = '0;
                w_if_valid_next = 1'b0;
            end
            default: begin
                w_state_next    = BOOT;
                w_pc_next       = RESET_PC;
                w_if_inst_next  = NOP_INST;
                w_if_pc4_next   = '0;
                w_if_valid_next = 1'b0;
            end
        endcase
    end

    assign Addr          = r_pc;
    assign IF_ID_Inst    = r_if_inst;
    assign IF_ID_PCPlus4 = r_if_pc4;
    assign IF_ID_Valid   = r_if_valid;
    assign Halted        = (r_state == HALTED);
    assign FetchCount    = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for the fetch stage: boot, stall, redirect priority, halt,
// asynchronous reset and PC wrap, against hand-computed expectations.
module tb_instruction_fetch_unit;

    logic        Clk;
    logic        Rst_n;
    logic [31:0] Addr;
    logic [31:0] Inst;
    logic        Stall;
    logic        Branch;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        JumpReg;
    logic [31:0] JumpRegTarget;
    logic        Halt;
    logic [31:0] IF_ID_Inst;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        Halted;
    logic [31:0] FetchCount;

    int n_total;
    int n_bad;

    // Instruction memory model: every word holds a distinct non-NOP pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA5A5_0000 ^ a;
    endfunction

    assign Inst = mem_word(Addr);

    instruction_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0000)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .Addr          (Addr),
        .Inst          (Inst),
        .Stall         (Stall),
        .Branch        (Branch),
        .BranchTarget  (BranchTarget),
        .Jump          (Jump),
        .JumpTarget    (JumpTarget),
        .JumpReg       (JumpReg),
        .JumpRegTarget (JumpRegTarget),
        .Halt          (Halt),
        .IF_ID_Inst    (IF_ID_Inst),
        .IF_ID_PCPlus4 (IF_ID_PCPlus4),
        .IF_ID_Valid   (IF_ID_Valid),
        .Halted        (Halted),
        .FetchCount    (FetchCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle to the falling edge for sampling/driving.
    task automatic tick(input string what);
        @(posedge Clk);
        @(negedge Clk);
        $display("t=%0t %-10s Addr=%08h IF_ID={%08h,%08h,%0b} Halted=%0b Count=%0d",
                 $time, what, Addr, IF_ID_Inst, IF_ID_PCPlus4, IF_ID_Valid, Halted, FetchCount);
    endtask

    task automatic clear_ctrl();
        Stall = 0; Branch = 0; Jump = 0; JumpReg = 0; Halt = 0;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] inst,
                              input logic [31:0] pc4, input logic valid);
        check({tag, ".inst"},  IF_ID_Inst,    inst);
        check({tag, ".pc4"},   IF_ID_PCPlus4, pc4);
        check({tag, ".valid"}, {31'd0, IF_ID_Valid}, {31'd0, valid});
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        Rst_n = 0;
        clear_ctrl();
        BranchTarget = 0; JumpTarget = 0; JumpRegTarget = 0;

        // Reset state
        @(negedge Clk);
        @(negedge Clk);
        check("rst.addr", Addr, 32'h0);
        check_ifid("rst", 32'h0, 32'h0, 1'b0);
        check("rst.halted", {31'd0, Halted}, 32'd0);
        check("rst.count", FetchCount, 32'd0);

        // Boot bubble then sequential fetch
        Rst_n = 1;
        tick("boot");
        check("boot.addr", Addr, 32'h0);
        check_ifid("boot", 32'h0, 32'h0, 1'b0);
        tick("fetch0");
        check_ifid("fetch0", mem_word(32'h0), 32'h4, 1'b1);
        check("fetch0.addr", Addr, 32'h4);
        tick("fetch1");
        check("fetch1.addr", Addr, 32'h8);
        tick("fetch2");
        check("fetch2.addr", Addr, 32'hC);
        check("fetch2.count", FetchCount, 32'd3);
        tick("fetch3");
        check("fetch3.addr", Addr, 32'h10);
        check_ifid("fetch3", mem_word(32'hC), 32'h10, 1'b1);

        // Stall for three cycles at 0x10
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            check("stall.addr", Addr, 32'h10);
            check_ifid("stall", mem_word(32'hC), 32'h10, 1'b1);
            check("stall.count", FetchCount, 32'd4);
        end
        Stall = 0;
        tick("resume");
        check("resume.addr", Addr, 32'h14);
        check_ifid("resume", mem_word(32'h10), 32'h14, 1'b1);
        check("resume.count", FetchCount, 32'd5);

        // Branch beats stall; unaligned target masked
        Branch = 1; BranchTarget = 32'h43; Stall = 1;
        tick("branch");
        check("branch.addr", Addr, 32'h40);
        check_ifid("branch", 32'h0, 32'h0, 1'b0);
        check("branch.count", FetchCount, 32'd5);
        clear_ctrl();
        tick("post_br");
        check_ifid("post_br", mem_word(32'h40), 32'h44, 1'b1);
        check("post_br.addr", Addr, 32'h44);

        // jr beats j beats branch
        Jump = 1; JumpTarget = 32'h80; JumpReg = 1; JumpRegTarget = 32'h100;
        Branch = 1; BranchTarget = 32'h200;
        tick("jr_prio");
        check("jr_prio.addr", Addr, 32'h100);
        check("jr_prio.valid", {31'd0, IF_ID_Valid}, 32'd0);
        clear_ctrl();
        tick("post_jr");
        check_ifid("post_jr", mem_word(32'h100), 32'h104, 1'b1);
        check("post_jr.count", FetchCount, 32'd7);

        Jump = 1; JumpTarget = 32'h82; Branch = 1; BranchTarget = 32'h200;
        tick("j_prio");
        check("j_prio.addr", Addr, 32'h80);
        clear_ctrl();
        tick("post_j");
        check_ifid("post_j", mem_word(32'h80), 32'h84, 1'b1);
        check("post_j.count", FetchCount, 32'd8);

        // Halt at 0x20, beating a simultaneous branch
        Jump = 1; JumpTarget = 32'h20;
        tick("to_20");
        check("to_20.addr", Addr, 32'h20);
        clear_ctrl();
        Halt = 1; Branch = 1; BranchTarget = 32'h300;
        tick("halt");
        check("halt.halted", {31'd0, Halted}, 32'd1);
        check("halt.addr", Addr, 32'h20);
        check_ifid("halt", 32'h0, 32'h0, 1'b0);
        check("halt.count", FetchCount, 32'd8);
        clear_ctrl();
        Branch = 1; BranchTarget = 32'h300;
        for (int i = 0; i < 2; i++) begin
            tick("halted");
            check("halted.addr", Addr, 32'h20);
            check("halted.flag", {31'd0, Halted}, 32'd1);
            check("halted.valid", {31'd0, IF_ID_Valid}, 32'd0);
        end
        clear_ctrl();

        // Asynchronous reset mid-halt, away from any clock edge
        #2;
        Rst_n = 0;
        #1;
        check("areset.addr", Addr, 32'h0);
        check("areset.halted", {31'd0, Halted}, 32'd0);
        check("areset.count", FetchCount, 32'd0);
        check_ifid("areset", 32'h0, 32'h0, 1'b0);
        $display("t=%0t %-10s Addr=%08h Halted=%0b Count=%0d", $time, "areset", Addr, Halted, FetchCount);

        // PC wrap from 0xFFFF_FFFC
        @(negedge Clk);
        Rst_n = 1;
        tick("boot2");
        JumpReg = 1; JumpRegTarget = 32'hFFFF_FFFF;
        tick("to_top");
        check("to_top.addr", Addr, 32'hFFFF_FFFC);
        clear_ctrl();
        tick("wrap");
        check("wrap.addr", Addr, 32'h0);
        check_ifid("wrap", mem_word(32'hFFFF_FFFC), 32'h0, 1'b1);
        check("wrap.count", FetchCount, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Hard time bound so the run cannot hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
